// File: rtl/rv32_pkg.sv
// Shared RV32I writeback definitions: widths, load funct3 codes, the buffered
// load-response entry and the byte/halfword extraction helper.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [1:0]            offset;
        logic [XLEN-1:0]       data;
    } load_entry_t;

    localparam int LOAD_ENTRY_W = $bits(load_entry_t);

    // Unknown funct3 codes fall through to the full word.
    function automatic logic [XLEN-1:0] load_extract(input load_entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        b = e.data[8*e.offset +: 8];
        h = e.data[16*e.offset[1] +: 16];
        case (e.funct3)
            F3_LB:   load_extract = {{24{b[7]}}, b};
            F3_LH:   load_extract = {{16{h[15]}}, h};
            F3_LBU:  load_extract = {24'd0, b};
            F3_LHU:  load_extract = {16'd0, h};
            default: load_extract = e.data;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous DEPTH-entry FIFO holding load responses until the write port is free.
module wb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter: ALU results win, buffered load responses
// drain when the ALU is idle or when starvation forces an ALU stall.
module writeback_unit
    import rv32_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_result,
    output logic                  alu_stall,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic [2:0]            mem_funct3,
    input  logic [1:0]            mem_offset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       write_data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    load_entry_t   in_entry;
    load_entry_t   head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;
    logic          alu_take;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pending;
    logic [31:0]   pending_next;

    assign in_entry  = '{rd: mem_rd, funct3: mem_funct3, offset: mem_offset, data: mem_data};
    assign mem_ready = (fifo_count != CW'(DEPTH));
    assign push      = mem_valid && !fifo_full;
    assign alu_stall = (starve_cnt == STARVE_TOP);
    assign pop       = !fifo_empty && (alu_stall || !alu_valid);
    // ALU data offered during a stall is a protocol violation and is dropped.
    assign alu_take  = alu_valid && !alu_stall;

    wb_fifo #(.DEPTH(DEPTH), .W(LOAD_ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else if (pop) begin
            reg_write  <= (head.rd != '0);
            rd         <= head.rd;
            write_data <= load_extract(head);
        end else if (alu_take) begin
            reg_write  <= (alu_rd != '0);
            rd         <= alu_rd;
            write_data <= alu_result;
        end else begin
            reg_write  <= 1'b0;
        end
    end

    // A non-empty FIFO that did not pop means the ALU won the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         starve_cnt <= '0;
        else if (pop || fifo_empty)      starve_cnt <= '0;
        else if (starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 1'b1;
    end

    // Set is applied after clear so a re-issue wins over the retiring load.
    always_comb begin
        pending_next = pending;
        if (pop) pending_next[head.rd] = 1'b0;
        if (issue_valid && issue_rd != '0) pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end

    assign busy_rs1 = pending[rs1];
    assign busy_rs2 = pending[rs2];

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a queue-based reference model checked every
// cycle, plus literal expectations for the headline scenarios.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_result = '0;
    logic        alu_stall;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic [2:0]  mem_funct3 = '0;
    logic [1:0]  mem_offset = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;

    int total = 0;
    int bad   = 0;

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_funct3(mem_funct3), .mem_offset(mem_offset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .reg_write(reg_write), .rd(rd), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit [4:0]  rd;
        bit [2:0]  f3;
        bit [1:0]  off;
        bit [31:0] d;
    } ent_t;

    ent_t      q[$];
    int        m_starve;
    bit        m_pend[32];
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_wd;

    function automatic bit [31:0] ref_ext(input ent_t e);
        bit [31:0] b;
        bit [31:0] h;
        b = (e.d >> (8 * int'(e.off))) & 32'h0000_00FF;
        h = (e.d >> (16 * (int'(e.off) / 2))) & 32'h0000_FFFF;
        case (int'(e.f3))
            0:       return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            1:       return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            4:       return b;
            5:       return h;
            default: return e.d;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_starve = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_we = 1'b0;
            m_rd = '0;
            m_wd = '0;
        end else begin
            bit   stall;
            bit   nonempty;
            bit   can_push;
            bit   popped;
            ent_t e;
            stall    = (m_starve == 7);
            nonempty = (q.size() != 0);
            can_push = (q.size() < 4);
            popped   = 1'b0;
            if (nonempty && (stall || !alu_valid)) begin
                e = q.pop_front();
                m_we = (e.rd != 0);
                m_rd = e.rd;
                m_wd = ref_ext(e);
                m_pend[e.rd] = 1'b0;
                popped = 1'b1;
            end else if (alu_valid) begin
                m_we = (alu_rd != 0);
                m_rd = alu_rd;
                m_wd = alu_result;
            end else begin
                m_we = 1'b0;
            end
            if (popped || !nonempty) m_starve = 0;
            else if (m_starve < 7)   m_starve = m_starve + 1;
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            if (mem_valid && can_push) begin
                e.rd = mem_rd; e.f3 = mem_funct3; e.off = mem_offset; e.d = mem_data;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_reg_write", 32'(reg_write), 32'(m_we));
            if (m_we) begin
                chk("m_rd", 32'(rd), 32'(m_rd));
                chk("m_write_data", write_data, m_wd);
            end
            chk("m_mem_ready", 32'(mem_ready), 32'(q.size() < 4));
            chk("m_alu_stall", 32'(alu_stall), 32'(m_starve == 7));
            chk("m_busy_rs1", 32'(busy_rs1), 32'(m_pend[rs1]));
            chk("m_busy_rs2", 32'(busy_rs2), 32'(m_pend[rs2]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] d);
        mem_valid = 1'b1; mem_rd = r; mem_funct3 = f3; mem_offset = off; mem_data = d;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } ext_vec_t;

    ext_vec_t ext_vec[5];
    int n;
    int nw;

    initial begin
        ext_vec[0] = '{3'b000, 2'd1, 32'hFFFF_FFF0};
        ext_vec[1] = '{3'b100, 2'd3, 32'h0000_0080};
        ext_vec[2] = '{3'b001, 2'd2, 32'hFFFF_8081};
        ext_vec[3] = '{3'b101, 2'd0, 32'h0000_F0FF};
        ext_vec[4] = '{3'b010, 2'd0, 32'h8081_F0FF};

        #2 rst = 1'b1;
        step(); step();
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_stall", 32'(alu_stall), 32'd0);
        rst = 1'b0;
        step();

        // ALU single-cycle write
        alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'hDEAD_BEEF;
        step();
        alu_valid = 1'b0;
        chk("alu_we", 32'(reg_write), 32'd1);
        chk("alu_rd", 32'(rd), 32'd1);
        chk("alu_wd", write_data, 32'hDEAD_BEEF);
        step();

        // load extraction, one response per case
        foreach (ext_vec[i]) begin
            load(5'd3, ext_vec[i].f3, ext_vec[i].off, 32'h8081_F0FF);
            step();
            mem_valid = 1'b0;
            step();
            chk($sformatf("ext%0d_we", i), 32'(reg_write), 32'd1);
            chk($sformatf("ext%0d_wd", i), write_data, ext_vec[i].exp);
        end
        step();

        // ALU priority fills the FIFO, starvation forces a drain
        alu_valid = 1'b1; alu_result = 32'h1234_0000;
        for (int i = 0; i < 4; i++) begin
            alu_rd = 5'(2 + i);
            load(5'(8 + i), 3'b010, 2'd0, 32'(100 + i));
            step();
        end
        mem_valid = 1'b0;
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        chk("full_alu_rd", 32'(rd), 32'd5);
        n = 3;
        while (!alu_stall && n < 20) begin
            alu_rd = 5'(2 + (n % 4));
            step();
            n++;
        end
        chk("starve_cycles", 32'(n), 32'd7);
        alu_valid = 1'b0;
        step();
        chk("drain_we", 32'(reg_write), 32'd1);
        chk("drain_rd", 32'(rd), 32'd8);
        chk("drain_wd", write_data, 32'd100);
        chk("drain_ready", 32'(mem_ready), 32'd1);
        step(); step(); step(); step();

        // scoreboard set and clear on retire
        issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5;
        step();
        issue_valid = 1'b0;
        chk("sb_busy_set", 32'(busy_rs1), 32'd1);
        step();
        load(5'd5, 3'b010, 2'd0, 32'hCAFE_0005);
        step();
        mem_valid = 1'b0;
        chk("sb_busy_hold", 32'(busy_rs1), 32'd1);
        step();
        chk("sb_ret_we", 32'(reg_write), 32'd1);
        chk("sb_ret_rd", 32'(rd), 32'd5);
        chk("sb_busy_clr", 32'(busy_rs1), 32'd0);

        // load to x0 is consumed without a write
        load(5'd0, 3'b010, 2'd0, 32'h5555_5555);
        step();
        mem_valid = 1'b0;
        step();
        chk("x0_we", 32'(reg_write), 32'd0);
        chk("x0_ready", 32'(mem_ready), 32'd1);

        // same-cycle set and clear of x7: set wins
        issue_valid = 1'b1; issue_rd = 5'd7; rs2 = 5'd7;
        step();
        issue_valid = 1'b0;
        load(5'd7, 3'b001, 2'd0, 32'h0000_7FFF);
        step();
        mem_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        chk("sc_we", 32'(reg_write), 32'd1);
        chk("sc_wd", write_data, 32'h0000_7FFF);
        chk("sc_busy", 32'(busy_rs2), 32'd1);
        load(5'd7, 3'b010, 2'd0, 32'h7777_7777);
        step();
        mem_valid = 1'b0;
        step();
        chk("sc_busy_clr", 32'(busy_rs2), 32'd0);

        // reset while three responses are buffered
        alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h0BAD_0BAD;
        rs1 = 5'd12; rs2 = 5'd13;
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(12 + i);
            load(5'(12 + i), 3'b010, 2'd0, 32'(200 + i));
            step();
        end
        issue_valid = 1'b0; mem_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy_rs1), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(reg_write), 32'd0);
        chk("mid_rst_ready", 32'(mem_ready), 32'd1);
        chk("mid_rst_busy1", 32'(busy_rs1), 32'd0);
        chk("mid_rst_busy2", 32'(busy_rs2), 32'd0);
        alu_valid = 1'b0;
        step();
        rst = 1'b0;
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (reg_write) nw++;
        end
        chk("no_stale_writes", 32'(nw), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Drives the register file write port (reg_write, rd, write_data) from two producers:
  - the ALU path, single-cycle, which has priority;
  - the load-response path, variable latency, buffered in a small FIFO.
- Applies RV32I load byte/halfword extraction and sign/zero extension.
- Keeps a per-register pending-load scoreboard, so decode can detect RAW hazards on rs1/rs2.

Parameters:
- DEPTH, 4, load-response FIFO entries (power of 2, >=2)
- STARVE_MAX, 7, consecutive ALU-won cycles with FIFO non-empty before a forced drain

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_result  in  32  ALU result
- alu_stall  out  1  upstream must hold alu_valid low this cycle (forced FIFO drain)
- mem_valid  in  1  load response valid
- mem_ready  out  1  FIFO can accept a load response
- mem_rd  in  5  load destination register
- mem_data  in  32  raw aligned word from data memory
- mem_funct3  in  3  load type
- mem_offset  in  2  byte address bits [1:0]
- issue_valid  in  1  decode issued a load
- issue_rd  in  5  destination of the issued load
- rs1  in  5  decode source 1 query
- rs2  in  5  decode source 2 query
- busy_rs1  out  1  rs1 has an outstanding load
- busy_rs2  out  1  rs2 has an outstanding load
- reg_write  out  1  register file write enable (registered)
- rd  out  5  register file write address (registered)
- write_data  out  32  register file write data (registered)

Behaviour:
- Reset (async, rst=1): FIFO empty, starve_cnt=0, pending[31:0]=0, reg_write=0, rd=0, write_data=0. Asserting rst mid-operation flushes all buffered responses and pending bits.
- FIFO push: when mem_valid && mem_ready. The entry stores {rd, funct3, offset, data}.
- mem_ready = (count != DEPTH). This is a registered-count compare with no combinational path from mem_valid.
- Selection each rising edge:
  - alu_stall=1 and FIFO non-empty: pop head, write it.
  - else alu_valid=1: write ALU result.
  - else FIFO non-empty: pop head, write it.
  - else reg_write<=0.
- Latency: one cycle from input (or FIFO head) to reg_write/rd/write_data.
- Destination x0: the entry is consumed as normal, but reg_write<=0.
- Push and pop may occur in the same cycle, and count is then unchanged. When full, no push can happen because mem_ready=0. Pointers wrap modulo DEPTH.
- starve_cnt:
  - +1 in each cycle where the FIFO is non-empty and the ALU wins;
  - cleared on any pop or when the FIFO is empty;
  - saturates at STARVE_MAX.
- alu_stall = (starve_cnt == STARVE_MAX), decoded from a register.
- If alu_valid=1 while alu_stall=1, that is a protocol violation. The ALU data is dropped and no error is flagged.
- Load extraction on the popped entry. Byte = data[8*offset +: 8]; halfword = data[16*offset[1] +: 16].
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend halfword
  - 010 LW: full word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend halfword
  - Other funct3: full word
- Scoreboard:
  - issue_valid && issue_rd!=0 sets pending[issue_rd].
  - A FIFO-sourced write clears pending[rd].
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is always 0.
- busy_rsN = pending[rsN], combinational. The bit is already clear in the cycle reg_write for that load is high, so the register file write and the decode read of that register fall in the same cycle.
- Decode must not issue a second load to a register that is still pending. An ALU write to a pending register is performed, and pending is unaffected.

Decomposition:
- Shared package rv32_pkg holds:
  - XLEN=32, REG_ADDR_W=5;
  - load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - the load-response entry struct/width.
- One sub-module: wb_fifo, a synchronous DEPTH-entry FIFO with push/pop/full/empty/count, async active-high reset.
- Load extraction is a combinational function placed in rv32_pkg.

Test Plan:
- ALU write: alu_valid=1, alu_rd=1, alu_result=32'hDEADBEEF -> next cycle reg_write=1, rd=1, write_data=32'hDEADBEEF.
- Load extraction: mem_data=32'h8081F0FF, all ALU-idle; one response per case. Expected write_data:
  - LB, offset 1: 32'hFFFFFFF0
  - LBU, offset 3: 32'h00000080
  - LH, offset 2: 32'hFFFF8081
  - LHU, offset 0: 32'h0000F0FF
  - LW: 32'h8081F0FF
- Priority/backpressure:
  - Keep alu_valid=1 with rd=2..5 and push 4 loads -> mem_ready=0 after the 4th push, no loads written.
  - 7 cycles later alu_stall=1 -> load head written, mem_ready=1.
- x0 and scoreboard:
  - issue_rd=5, then rs1=5 -> busy_rs1=1 until the load write cycle, then 0.
  - A load to rd=0 -> entry popped, reg_write=0.
- Simultaneous set/clear: issue_valid with issue_rd=7 in the same cycle as the load to x7 retires -> pending[7] stays 1.
- Reset mid-operation: rst pulse while the FIFO holds 3 entries -> immediately reg_write=0, mem_ready=1, busy_rs1=busy_rs2=0. No stale writes afterwards.
